// File: rtl/ee354_gcd_arbiter.sv
// ee354_gcd_arbiter: round-robin front end that shares one ee354_GCD core
// between two requesters. Operands containing a zero are answered locally
// (gcd(0,b)=b) without touching the core.
// Optional build macro: GCD_ARB_TIMEOUT_EN adds a WAIT watchdog that forces
// an error completion after TIMEOUT cycles without Core_q_Done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no pulses; pick a winner, launch, bypass or wait for q_I
// LAUNCH | Gnt(winner) and Core_Start asserted for one cycle
// WAIT   | core busy; Cycles counts, wait for Core_q_Done
// ACK    | Core_Ack and Done(winner) asserted for one cycle
// BYPASS | zero operand: Gnt and Done(winner) together, Result = A|B
module ee354_gcd_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             CEN,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Ain0,
    input  logic [WIDTH-1:0] Bin0,
    input  logic [WIDTH-1:0] Ain1,
    input  logic [WIDTH-1:0] Bin1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] Result,
    output logic             Err,
    output logic [CNT_W-1:0] Cycles,
    output logic             Core_Start,
    output logic             Core_Ack,
    output logic [WIDTH-1:0] Core_Ain,
    output logic [WIDTH-1:0] Core_Bin,
    input  logic             Core_q_I,
    input  logic             Core_q_Done,
    input  logic [WIDTH-1:0] Core_AB_GCD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACK,
        S_BYPASS
    } state_t;

    localparam logic [CNT_W-1:0] CYCLES_MAX = '1;

    state_t           state;
    logic             last;
    logic             win;
    logic             req_any;
    logic             pick;
    logic [WIDTH-1:0] pick_a;
    logic [WIDTH-1:0] pick_b;
    logic             pick_zero;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        req_any   = Req0 | Req1;
        pick      = (Req0 && Req1) ? ~last : Req1;
        pick_a    = pick ? Ain1 : Ain0;
        pick_b    = pick ? Bin1 : Bin0;
        pick_zero = (pick_a == '0) || (pick_b == '0);
    end

    // Sequencer with registered pulses; CEN low freezes everything, stretching pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            win        <= 1'b0;
            Gnt0       <= 1'b0;
            Gnt1       <= 1'b0;
            Done0      <= 1'b0;
            Done1      <= 1'b0;
            Core_Start <= 1'b0;
            Core_Ack   <= 1'b0;
            Result     <= '0;
            Cycles     <= '0;
            Core_Ain   <= '0;
            Core_Bin   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else if (CEN) begin
            Gnt0       <= 1'b0;
            Gnt1       <= 1'b0;
            Done0      <= 1'b0;
            Done1      <= 1'b0;
            Core_Start <= 1'b0;
            Core_Ack   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        if (pick_zero) begin
                            state  <= S_BYPASS;
                            last   <= pick;
                            win    <= pick;
                            Gnt0   <= ~pick;
                            Gnt1   <= pick;
                            Done0  <= ~pick;
                            Done1  <= pick;
                            Result <= pick_a | pick_b;
                            Cycles <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
                            err_q  <= 1'b0;
`endif
                        end else if (Core_q_I) begin
                            state      <= S_LAUNCH;
                            last       <= pick;
                            win        <= pick;
                            Gnt0       <= ~pick;
                            Gnt1       <= pick;
                            Core_Start <= 1'b1;
                            Core_Ain   <= pick_a;
                            Core_Bin   <= pick_b;
                            Cycles     <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
                            wd_cnt     <= WD_W'(TIMEOUT - 1);
`endif
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Every WAIT clock counts, including the one that sees q_Done.
                    if (Cycles != CYCLES_MAX) begin
                        Cycles <= Cycles + 1'b1;
                    end
                    if (Core_q_Done) begin
                        Result   <= Core_AB_GCD;
                        state    <= S_ACK;
                        Core_Ack <= 1'b1;
                        Done0    <= ~win;
                        Done1    <= win;
`ifdef GCD_ARB_TIMEOUT_EN
                        err_q    <= 1'b0;
                    end else if (wd_cnt == '0) begin
                        Result   <= '0;
                        err_q    <= 1'b1;
                        state    <= S_ACK;
                        Core_Ack <= 1'b1;
                        Done0    <= ~win;
                        Done1    <= win;
                    end else begin
                        wd_cnt   <= wd_cnt - 1'b1;
`endif
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                S_BYPASS: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
